// File: rtl/motion_object_engine.sv
// NUM_OBJ bouncing rectangles with frame-shadowed positions and a registered per-pixel lookup.
// Define MOTION_OBJ_HIT_IDX_EN to add the hit_idx output (winning channel index).
module motion_object_engine #(
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned COORD_W = 9,
  parameter int unsigned DIV_W   = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  input  logic               frame_start,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_axis,
  input  logic [COORD_W-1:0] cfg_min,
  input  logic [COORD_W-1:0] cfg_max,
  input  logic [COORD_W-1:0] cfg_fixed,
  input  logic [COORD_W-1:0] cfg_len,
  input  logic [COORD_W-1:0] cfg_hgt,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [2:0]         cfg_colour,
  input  logic [COORD_W-1:0] x_cord,
  input  logic [COORD_W-1:0] y_cord,
  output logic [2:0]         colour,
  output logic               hit
`ifdef MOTION_OBJ_HIT_IDX_EN
  ,
  output logic [IDX_W-1:0]   hit_idx
`endif
);

  localparam int unsigned SumW = COORD_W + 1;

  logic               act_q   [NUM_OBJ];
  logic               axis_q  [NUM_OBJ];
  logic [COORD_W-1:0] min_q   [NUM_OBJ];
  logic [COORD_W-1:0] max_q   [NUM_OBJ];
  logic [COORD_W-1:0] fixed_q [NUM_OBJ];
  logic [COORD_W-1:0] len_q   [NUM_OBJ];
  logic [COORD_W-1:0] hgt_q   [NUM_OBJ];
  logic [DIV_W-1:0]   div_q   [NUM_OBJ];
  logic [2:0]         col_q   [NUM_OBJ];
  logic [COORD_W-1:0] pos_q   [NUM_OBJ];
  logic [COORD_W-1:0] pos_d   [NUM_OBJ];
  logic               dir_q   [NUM_OBJ];
  logic               dir_d   [NUM_OBJ];
  logic [DIV_W-1:0]   cnt_q   [NUM_OBJ];
  logic [DIV_W-1:0]   cnt_d   [NUM_OBJ];
  logic [COORD_W-1:0] spos_q  [NUM_OBJ];
  logic               sact_q  [NUM_OBJ];

  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      pos_d[i] = pos_q[i];
      dir_d[i] = dir_q[i];
      cnt_d[i] = cnt_q[i];
      if (enable && div_q[i] != '0) begin
        if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
          cnt_d[i] = '0;
          // min >= max leaves the channel parked at min
          if (min_q[i] < max_q[i]) begin
            if (pos_q[i] >= max_q[i]) begin
              dir_d[i] = 1'b1;
              pos_d[i] = pos_q[i] - COORD_W'(1);
            end else if (pos_q[i] <= min_q[i]) begin
              dir_d[i] = 1'b0;
              pos_d[i] = pos_q[i] + COORD_W'(1);
            end else begin
              pos_d[i] = dir_q[i] ? pos_q[i] - COORD_W'(1) : pos_q[i] + COORD_W'(1);
            end
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        act_q[i]   <= 1'b0;
        axis_q[i]  <= 1'b0;
        min_q[i]   <= '0;
        max_q[i]   <= '0;
        fixed_q[i] <= '0;
        len_q[i]   <= '0;
        hgt_q[i]   <= '0;
        div_q[i]   <= '0;
        col_q[i]   <= '0;
        pos_q[i]   <= '0;
        dir_q[i]   <= 1'b0;
        cnt_q[i]   <= '0;
        spos_q[i]  <= '0;
        sact_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (frame_start) begin
          spos_q[i] <= pos_q[i];
          sact_q[i] <= act_q[i];
        end
        if (cfg_we && cfg_idx == IDX_W'(i)) begin
          act_q[i]   <= 1'b1;
          axis_q[i]  <= cfg_axis;
          min_q[i]   <= cfg_min;
          max_q[i]   <= cfg_max;
          fixed_q[i] <= cfg_fixed;
          len_q[i]   <= cfg_len;
          hgt_q[i]   <= cfg_hgt;
          div_q[i]   <= cfg_div;
          col_q[i]   <= cfg_colour;
          pos_q[i]   <= cfg_min;
          dir_q[i]   <= 1'b0;
          cnt_q[i]   <= '0;
        end else begin
          pos_q[i] <= pos_d[i];
          dir_q[i] <= dir_d[i];
          cnt_q[i] <= cnt_d[i];
        end
      end
    end
  end

  logic [2:0]      colour_d;
  logic            hit_d;
  logic [SumW-1:0] ox, oy, xq, yq;
`ifdef MOTION_OBJ_HIT_IDX_EN
  logic [IDX_W-1:0] idx_d;
`endif

  assign xq = {1'b0, x_cord};
  assign yq = {1'b0, y_cord};

  // Ascending scan; the first hit locks out higher indices
  always_comb begin
    colour_d = '0;
    hit_d    = 1'b0;
    ox       = '0;
    oy       = '0;
`ifdef MOTION_OBJ_HIT_IDX_EN
    idx_d    = '0;
`endif
    for (int i = 0; i < NUM_OBJ; i++) begin
      ox = axis_q[i] ? {1'b0, fixed_q[i]} : {1'b0, spos_q[i]};
      oy = axis_q[i] ? {1'b0, spos_q[i]} : {1'b0, fixed_q[i]};
      if (!hit_d && sact_q[i] && xq >= ox && xq <= ox + {1'b0, len_q[i]} &&
          yq >= oy && yq <= oy + {1'b0, hgt_q[i]}) begin
        hit_d    = 1'b1;
        colour_d = col_q[i];
`ifdef MOTION_OBJ_HIT_IDX_EN
        idx_d    = IDX_W'(i);
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      colour  <= '0;
      hit     <= 1'b0;
`ifdef MOTION_OBJ_HIT_IDX_EN
      hit_idx <= '0;
`endif
    end else begin
      colour  <= colour_d;
      hit     <= hit_d;
`ifdef MOTION_OBJ_HIT_IDX_EN
      hit_idx <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_motion_object_engine.sv
// Scoreboard bench for motion_object_engine: a triangle-wave position model predicts
// every pixel query; a negedge monitor pops and compares the registered responses.
module tb_motion_object_engine;

  localparam int NUM_OBJ = 3;
  localparam int IDX_W   = 2;
  localparam int COORD_W = 9;
  localparam int DIV_W   = 8;
  localparam int CMAX    = (1 << COORD_W) - 1;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               enable = 1'b0;
  logic               frame_start = 1'b0;
  logic               cfg_we = 1'b0;
  logic [IDX_W-1:0]   cfg_idx = '0;
  logic               cfg_axis = 1'b0;
  logic [COORD_W-1:0] cfg_min = '0, cfg_max = '0, cfg_fixed = '0, cfg_len = '0, cfg_hgt = '0;
  logic [DIV_W-1:0]   cfg_div = '0;
  logic [2:0]         cfg_colour = '0;
  logic [COORD_W-1:0] x_cord = '0, y_cord = '0;
  logic [2:0]         colour;
  logic               hit;
`ifdef MOTION_OBJ_HIT_IDX_EN
  logic [IDX_W-1:0]   hit_idx;
`endif

  motion_object_engine #(
    .NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W), .COORD_W(COORD_W), .DIV_W(DIV_W)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .frame_start(frame_start),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_axis(cfg_axis), .cfg_min(cfg_min),
    .cfg_max(cfg_max), .cfg_fixed(cfg_fixed), .cfg_len(cfg_len), .cfg_hgt(cfg_hgt),
    .cfg_div(cfg_div), .cfg_colour(cfg_colour), .x_cord(x_cord), .y_cord(y_cord),
    .colour(colour), .hit(hit)
`ifdef MOTION_OBJ_HIT_IDX_EN
    , .hit_idx(hit_idx)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: position derived from enabled clocks since the last write
  int m_act[NUM_OBJ], m_axis[NUM_OBJ], m_min[NUM_OBJ], m_max[NUM_OBJ], m_fixed[NUM_OBJ];
  int m_len[NUM_OBJ], m_hgt[NUM_OBJ], m_div[NUM_OBJ], m_col[NUM_OBJ], m_n[NUM_OBJ];
  int sh_act[NUM_OBJ], sh_pos[NUM_OBJ];

  typedef struct {
    int col;
    int hit;
    int idx;
  } exp_t;
  exp_t sb[$];

  int passed = 0;
  int total  = 0;
  logic qv = 1'b0;
  logic resp_due;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int live_pos(input int i);
    int t, r, ph;
    if (m_div[i] == 0 || m_min[i] >= m_max[i]) return m_min[i];
    t  = m_n[i] / m_div[i];
    r  = m_max[i] - m_min[i];
    ph = t % (2 * r);
    return (ph <= r) ? m_min[i] + ph : m_min[i] + 2 * r - ph;
  endfunction

  function automatic exp_t model_query(input int x, input int y);
    exp_t e;
    int ox, oy;
    e.col = 0; e.hit = 0; e.idx = 0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      ox = m_axis[i] ? m_fixed[i] : sh_pos[i];
      oy = m_axis[i] ? sh_pos[i] : m_fixed[i];
      if (sh_act[i] != 0 && x >= ox && x <= ox + m_len[i] && y >= oy && y <= oy + m_hgt[i]) begin
        e.col = m_col[i]; e.hit = 1; e.idx = i;
        return e;
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_OBJ; i++) begin
      m_act[i] = 0; m_axis[i] = 0; m_min[i] = 0; m_max[i] = 0; m_fixed[i] = 0;
      m_len[i] = 0; m_hgt[i] = 0; m_div[i] = 0; m_col[i] = 0; m_n[i] = 0;
      sh_act[i] = 0; sh_pos[i] = 0;
    end
  endtask

  // One clock: predict the query, let the edge happen, advance the model
  task automatic cycle();
    if (qv) sb.push_back(model_query(int'(x_cord), int'(y_cord)));
    @(posedge clock);
    if (frame_start)
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_pos[i] = live_pos(i);
        sh_act[i] = m_act[i];
      end
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (cfg_we && int'(cfg_idx) == i) begin
        m_act[i] = 1; m_axis[i] = int'(cfg_axis); m_min[i] = int'(cfg_min);
        m_max[i] = int'(cfg_max); m_fixed[i] = int'(cfg_fixed); m_len[i] = int'(cfg_len);
        m_hgt[i] = int'(cfg_hgt); m_div[i] = int'(cfg_div); m_col[i] = int'(cfg_colour);
        m_n[i] = 0;
      end else if (enable) begin
        m_n[i]++;
      end
    end
    #1;
  endtask

  task automatic write(input int idx, input int axis, input int mn, input int mx, input int fx,
                       input int ln, input int hg, input int dv, input int col);
    cfg_idx = IDX_W'(idx); cfg_axis = axis[0]; cfg_min = COORD_W'(mn); cfg_max = COORD_W'(mx);
    cfg_fixed = COORD_W'(fx); cfg_len = COORD_W'(ln); cfg_hgt = COORD_W'(hg);
    cfg_div = DIV_W'(dv); cfg_colour = col[2:0]; cfg_we = 1'b1;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic query(input int x, input int y, input bit fs);
    x_cord = COORD_W'(x); y_cord = COORD_W'(y); qv = 1'b1; frame_start = fs;
    cycle();
    qv = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  function automatic int clampc(input int v);
    return (v < 0) ? 0 : ((v > CMAX) ? CMAX : v);
  endfunction

  task automatic query_near(input bit fs);
    int c, bx, by;
    c  = $urandom_range(NUM_OBJ - 1);
    bx = m_axis[c] ? m_fixed[c] : m_min[c];
    by = m_axis[c] ? m_min[c] : m_fixed[c];
    query(clampc(bx - 3 + $urandom_range(m_len[c] + 8 + (m_axis[c] ? 0 : 20))),
          clampc(by - 3 + $urandom_range(m_hgt[c] + 8 + (m_axis[c] ? 20 : 0))), fs);
  endtask

  always @(posedge clock or negedge resetn)
    if (!resetn) resp_due <= 1'b0;
    else         resp_due <= qv;

  always @(negedge clock) begin
    if (resp_due) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("colour", int'(colour), e.col);
        check("hit", int'(hit), e.hit);
`ifdef MOTION_OBJ_HIT_IDX_EN
        check("hit_idx", int'(hit_idx), e.idx);
`endif
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_colour", int'(colour), 0);
    check("reset_hit", int'(hit), 0);
    resetn = 1'b1;
    cycle();

    // Nothing active after reset
    for (int k = 0; k < 4; k++) query($urandom_range(CMAX), $urandom_range(CMAX), k[0]);

    // Basic geometry of ch0 at pos=40
    write(0, 0, 40, 43, 60, 40, 3, 2, 5);
    pulse_fs();
    query(40, 60, 0);
    query(81, 60, 0);
    query(80, 63, 0);
    query(39, 60, 0);
    query(40, 64, 0);

    // Overlap priority at (100,100)
    write(0, 1, 90, 95, 95, 10, 20, 3, 7);
    write(1, 0, 95, 100, 95, 10, 10, 2, 6);
    pulse_fs();
    query(100, 100, 0);
    query(106, 100, 0);

    // Bouncing 40..43, one tick per 2 clocks, shadow refreshed every cycle
    write(0, 0, 40, 43, 60, 40, 3, 2, 5);
    enable = 1'b1;
    for (int k = 0; k < 24; k++) query((k % 2) ? 40 + (k % 4) : 80 + (k % 4), 61, 1);
    // Motion continues but without frame_start the display is stale
    for (int k = 0; k < 10; k++) query(40 + (k % 4), 60, 0);
    pulse_fs();
    // Frozen motion
    enable = 1'b0;
    for (int k = 0; k < 10; k++) query(40 + (k % 4), 62, 1);
    enable = 1'b1;

    // div=0, min==max, min>max and an out-of-range index
    write(2, 0, 200, 250, 200, 5, 5, 0, 3);
    write(1, 1, 10, 10, 300, 4, 4, 1, 4);
    write(0, 0, 30, 20, 450, 6, 6, 1, 2);
    write(3, 0, 0, 50, 0, 511, 511, 1, 1);
    for (int k = 0; k < 12; k++) begin
      query(200 + (k % 7), 202, 1);
      query(302, 9 + (k % 7), 0);
      query(30 + (k % 8), 452, 0);
    end

    // Randomised rounds
    for (int r = 0; r < 40; r++) begin
      enable = 1'($urandom_range(1));
      for (int w = 0; w < 1 + int'($urandom_range(2)); w++) begin
        int mn, mx, sel;
        mn  = $urandom_range(CMAX);
        sel = $urandom_range(7);
        mx  = (sel == 0) ? mn : ((sel == 1) ? clampc(mn - 5) : clampc(mn + 1 + $urandom_range(12)));
        write($urandom_range(3), $urandom_range(1), mn, mx, $urandom_range(CMAX),
              ($urandom_range(5) == 0) ? $urandom_range(CMAX) : $urandom_range(30),
              ($urandom_range(5) == 0) ? $urandom_range(CMAX) : $urandom_range(30),
              $urandom_range(4), $urandom_range(7));
      end
      pulse_fs();
      for (int k = 0; k < 40; k++) begin
        enable = ($urandom_range(4) != 0);
        query_near($urandom_range(3) == 0);
      end
    end

    // Asynchronous reset while a hit is on the output
    enable = 1'b0;
    write(0, 0, 100, 120, 100, 10, 10, 1, 6);
    pulse_fs();
    query(105, 105, 0);
    cycle();
    cycle();
    check("pre_reset_hit", int'(hit), 1);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_hit", int'(hit), 0);
    check("async_reset_colour", int'(colour), 0);
    model_reset();
    @(posedge clock);
    #1 resetn = 1'b1;
    cycle();
    pulse_fs();
    query(105, 105, 0);
    query(0, 0, 1);
    query(105, 105, 0);
    cycle();
    cycle();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
